// File: rtl/seq_divider_32.sv
// Multi-cycle 32-bit signed restoring divider: one quotient bit per clock, {remainder, quotient} result.
// Optional macro DIV_UNSIGNED_SUPPORT_EN adds the in_unsigned port for unsigned division.
module seq_divider_32 (
    input  logic        in_clk,
    input  logic        in_rst_n,
    input  logic [31:0] in_dividend,
    input  logic [31:0] in_divisor,
    input  logic        in_start,
`ifdef DIV_UNSIGNED_SUPPORT_EN
    input  logic        in_unsigned,
`endif
    output logic        out_busy,
    output logic        out_done,
    output logic        out_div_zero,
    output logic [63:0] out_result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [5:0]  cnt_q;
    logic        dz_q;

    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dsr_q;
    logic        sign_q_q;
    logic        sign_r_q;

    // |0x80000000| stays 0x80000000 when viewed as an unsigned magnitude.
    function automatic logic [31:0] magnitude(input logic signed [31:0] v);
        magnitude = v[31] ? 32'(-v) : 32'(v);
    endfunction

    function automatic logic [31:0] negate_if(input logic [31:0] v, input logic neg);
        negate_if = neg ? (~v + 32'd1) : v;
    endfunction

    logic unsigned_mode;
`ifdef DIV_UNSIGNED_SUPPORT_EN
    assign unsigned_mode = in_unsigned;
`else
    assign unsigned_mode = 1'b0;
`endif

    logic signed [31:0] dvd_s;
    logic signed [31:0] dsr_s;
    logic        [31:0] dvd_mag;
    logic        [31:0] dsr_mag;
    logic               accept;
    logic               dsr_zero;

    assign dvd_s    = in_dividend;
    assign dsr_s    = in_divisor;
    assign dvd_mag  = unsigned_mode ? in_dividend : magnitude(dvd_s);
    assign dsr_mag  = unsigned_mode ? in_divisor  : magnitude(dsr_s);
    assign accept   = in_start && ((state == IDLE) || (state == DONE));
    assign dsr_zero = (in_divisor == 32'd0);

    // Restoring step: the subtraction fits 32 bits whenever the 33-bit compare passes.
    logic [32:0] rem_shift;
    logic [31:0] rem_sub;
    logic        step_ge;
    logic        stepping;

    assign rem_shift = {rem_q, quo_q[31]};
    assign step_ge   = (rem_shift >= {1'b0, dsr_q});
    assign rem_sub   = rem_shift[31:0] - dsr_q;
    assign stepping  = (state == ITER) && (cnt_q != 6'd0);

    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [63:0] result_next;

    // On divide-by-zero quo_q carries the raw dividend, which becomes the remainder.
    assign quo_fix     = negate_if(quo_q, sign_q_q);
    assign rem_fix     = negate_if(rem_q, sign_r_q);
    assign result_next = dz_q ? {quo_q, 32'hFFFF_FFFF} : {rem_fix, quo_fix};

    // Control FSM and registered outputs.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state        <= IDLE;
            cnt_q        <= 6'd0;
            dz_q         <= 1'b0;
            out_div_zero <= 1'b0;
            out_result   <= 64'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        out_div_zero <= 1'b0;
                        dz_q         <= dsr_zero;
                        cnt_q        <= dsr_zero ? 6'd0 : 6'd32;
                        state        <= ITER;
                    end else begin
                        state <= IDLE;
                    end
                end
                ITER: begin
                    if (cnt_q != 6'd0) begin
                        cnt_q <= cnt_q - 6'd1;
                    end else begin
                        out_result   <= result_next;
                        out_div_zero <= dz_q;
                        state        <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath registers; meaningful only between accept and the result write.
    always_ff @(posedge in_clk) begin
        if (accept) begin
            sign_q_q <= ~unsigned_mode & (in_dividend[31] ^ in_divisor[31]);
            sign_r_q <= ~unsigned_mode & in_dividend[31];
            rem_q    <= 32'd0;
            quo_q    <= dsr_zero ? in_dividend : dvd_mag;
            dsr_q    <= dsr_mag;
        end else if (stepping) begin
            rem_q <= step_ge ? rem_sub : rem_shift[31:0];
            quo_q <= {quo_q[30:0], step_ge};
        end
    end

    assign out_busy = (state == ITER);
    assign out_done = (state == DONE);

endmodule
